primary_reexe_stage: RTL and testbench

- Re-execute stage of the primary pipe, sitting between EXE and the primary branch-amend/writeback stage.
- Takes one instruction per handshake from EXE. Any source operand flagged stale (load-use) is refreshed from the downstream stage's forwarding bus.
- Recomputes the result (pass/add/sub/mul) when requested, then presents it downstream with a valid/allowin handshake.
- Also drives a forwarding bus for EXE.

---
 rtl/primary_reexe_stage_pkg.sv | 24 ++
 rtl/primary_reexe_stage_if.sv | 51 +++++
 rtl/primary_reexe_stage_operand_refresh.sv | 64 ++++++
 rtl/primary_reexe_stage.sv | 177 +++++++++++++++++
 tb/tb_primary_reexe_stage.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/primary_reexe_stage_pkg.sv
// Shared definitions for the primary-pipe re-execute stage: op and state
// encodings plus the common GPR / word widths.
package primary_reexe_stage_pkg;

    localparam int GPR_NUM     = 5;
    localparam int SINGLE_WORD = 32;

    localparam logic [SINGLE_WORD-1:0] ZEROWORD = '0;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_MUL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_CALC = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/primary_reexe_stage_if.sv
// Bundle of the EXE-side, PBA-side and stage-output signals of the re-execute
// stage; master is the surrounding pipeline, slave is the stage itself.
interface primary_reexe_stage_if #(
    parameter int DATA_W = 32
);
    import primary_reexe_stage_pkg::*;

    logic                   EXE_valid_w_i;
    logic                   REEXE_allowin_w_o;
    logic [GPR_NUM-1:0]     EXE_writeNum_i;
    logic [SINGLE_WORD-1:0] EXE_VAddr_i;
    logic [DATA_W-1:0]      EXE_regData_i;
    logic [1:0]             EXE_op_i;
    logic [DATA_W-1:0]      EXE_srcA_i;
    logic [DATA_W-1:0]      EXE_srcB_i;
    logic [GPR_NUM-1:0]     EXE_srcANum_i;
    logic [GPR_NUM-1:0]     EXE_srcBNum_i;
    logic                   EXE_srcAStale_i;
    logic                   EXE_srcBStale_i;

    logic                   PBA_okToChange_w_i;
    logic                   PBA_writeEnable_w_i;
    logic [GPR_NUM-1:0]     PBA_writeNum_w_i;
    logic [DATA_W-1:0]      PBA_forwardData_w_i;

    logic                   REEXE_valid_w_o;
    logic [GPR_NUM-1:0]     REEXE_writeNum_o;
    logic [SINGLE_WORD-1:0] REEXE_VAddr_o;
    logic [DATA_W-1:0]      REEXE_regData_o;
    logic                   REEXE_fwdValid_w_o;
    logic [GPR_NUM-1:0]     REEXE_fwdNum_w_o;

    modport master (
        output EXE_valid_w_i, EXE_writeNum_i, EXE_VAddr_i, EXE_regData_i, EXE_op_i,
               EXE_srcA_i, EXE_srcB_i, EXE_srcANum_i, EXE_srcBNum_i,
               EXE_srcAStale_i, EXE_srcBStale_i,
               PBA_okToChange_w_i, PBA_writeEnable_w_i, PBA_writeNum_w_i, PBA_forwardData_w_i,
        input  REEXE_allowin_w_o, REEXE_valid_w_o, REEXE_writeNum_o, REEXE_VAddr_o,
               REEXE_regData_o, REEXE_fwdValid_w_o, REEXE_fwdNum_w_o
    );

    modport slave (
        input  EXE_valid_w_i, EXE_writeNum_i, EXE_VAddr_i, EXE_regData_i, EXE_op_i,
               EXE_srcA_i, EXE_srcB_i, EXE_srcANum_i, EXE_srcBNum_i,
               EXE_srcAStale_i, EXE_srcBStale_i,
               PBA_okToChange_w_i, PBA_writeEnable_w_i, PBA_writeNum_w_i, PBA_forwardData_w_i,
        output REEXE_allowin_w_o, REEXE_valid_w_o, REEXE_writeNum_o, REEXE_VAddr_o,
               REEXE_regData_o, REEXE_fwdValid_w_o, REEXE_fwdNum_w_o
    );

endinterface

// File: rtl/primary_reexe_stage_operand_refresh.sv
// One source operand of the re-execute stage: captured on accept, then
// refreshed from the downstream forwarding bus while its stale flag is set.
module reexe_operand_refresh
    import primary_reexe_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               wait_i,
    input  logic [DATA_W-1:0]  src_i,
    input  logic [GPR_NUM-1:0] num_i,
    input  logic               stale_i,
    input  logic               fwd_en_i,
    input  logic [GPR_NUM-1:0] fwd_num_i,
    input  logic [DATA_W-1:0]  fwd_data_i,
    output logic [DATA_W-1:0]  operand_nxt_o,
    output logic               stale_nxt_o
);

    logic [DATA_W-1:0]  operand_q, operand_d;
    logic [GPR_NUM-1:0] num_q, num_d;
    logic               stale_q, stale_d;

    // r0 is hardwired zero, so a stale r0 operand never needs a forward.
    always_comb begin
        operand_d = operand_q;
        num_d     = num_q;
        stale_d   = stale_q;
        if (flush_i) begin
            stale_d = 1'b0;
        end else if (load_i) begin
            num_d = num_i;
            if (stale_i && num_i == '0) begin
                operand_d = DATA_W'(ZEROWORD);
                stale_d   = 1'b0;
            end else begin
                operand_d = src_i;
                stale_d   = stale_i;
            end
        end else if (wait_i && stale_q && fwd_en_i && fwd_num_i == num_q) begin
            operand_d = fwd_data_i;
            stale_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_q <= '0;
            num_q     <= '0;
            stale_q   <= 1'b0;
        end else begin
            operand_q <= operand_d;
            num_q     <= num_d;
            stale_q   <= stale_d;
        end
    end

    assign operand_nxt_o = operand_d;
    assign stale_nxt_o   = stale_d;

endmodule

// File: rtl/primary_reexe_stage.sv
// Re-execute stage of the primary pipe: refreshes load-use operands, recomputes
// PASS/ADD/SUB/MUL and hands the result to branch-amend with valid/allowin.
module primary_reexe_stage
    import primary_reexe_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DATA_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_w_i,
    primary_reexe_stage_if.slave bus
);

    localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    op_e                    op_q, op_d;
    logic [GPR_NUM-1:0]     write_num_q, write_num_d;
    logic [SINGLE_WORD-1:0] vaddr_q, vaddr_d;
    logic [DATA_W-1:0]      pass_q, pass_d;
    logic [DATA_W-1:0]      result_q, result_d;
    logic                   valid_q, valid_d;
    logic                   fwd_valid_q, fwd_valid_d;
    logic [GPR_NUM-1:0]     fwd_num_q, fwd_num_d;

    logic                   allowin;
    logic                   accept;
    logic [DATA_W-1:0]      a_nxt, b_nxt;
    logic                   a_stale_nxt, b_stale_nxt;

    function automatic logic [DATA_W-1:0] alu(input op_e op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] pass);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            default: return pass;
        endcase
    endfunction

    assign allowin = !flush_w_i &&
                     (state_q == ST_IDLE || (state_q == ST_DONE && bus.PBA_okToChange_w_i));
    assign accept  = bus.EXE_valid_w_i && allowin;

    reexe_operand_refresh #(.DATA_W(DATA_W)) u_src_a (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_w_i),
        .load_i        (accept),
        .wait_i        (state_q == ST_WAIT),
        .src_i         (bus.EXE_srcA_i),
        .num_i         (bus.EXE_srcANum_i),
        .stale_i       (bus.EXE_srcAStale_i),
        .fwd_en_i      (bus.PBA_writeEnable_w_i),
        .fwd_num_i     (bus.PBA_writeNum_w_i),
        .fwd_data_i    (bus.PBA_forwardData_w_i),
        .operand_nxt_o (a_nxt),
        .stale_nxt_o   (a_stale_nxt)
    );

    reexe_operand_refresh #(.DATA_W(DATA_W)) u_src_b (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_w_i),
        .load_i        (accept),
        .wait_i        (state_q == ST_WAIT),
        .src_i         (bus.EXE_srcB_i),
        .num_i         (bus.EXE_srcBNum_i),
        .stale_i       (bus.EXE_srcBStale_i),
        .fwd_en_i      (bus.PBA_writeEnable_w_i),
        .fwd_num_i     (bus.PBA_writeNum_w_i),
        .fwd_data_i    (bus.PBA_forwardData_w_i),
        .operand_nxt_o (b_nxt),
        .stale_nxt_o   (b_stale_nxt)
    );

    // A new accept always overrides the per-state progress below, which is what
    // makes DONE -> next instruction back-to-back without an IDLE bubble.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        write_num_d = write_num_q;
        vaddr_d     = vaddr_q;
        pass_d      = pass_q;
        result_d    = result_q;

        if (flush_w_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (!a_stale_nxt && !b_stale_nxt) begin
                        if (op_q == OP_MUL) begin
                            state_d = ST_CALC;
                            cnt_d   = MUL_INIT;
                        end else begin
                            state_d  = ST_DONE;
                            result_d = alu(op_q, a_nxt, b_nxt, pass_q);
                        end
                    end
                end
                ST_CALC: begin
                    if (cnt_q == '0) begin
                        state_d  = ST_DONE;
                        result_d = alu(OP_MUL, a_nxt, b_nxt, pass_q);
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.PBA_okToChange_w_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (accept) begin
                op_d        = op_e'(bus.EXE_op_i);
                write_num_d = bus.EXE_writeNum_i;
                vaddr_d     = bus.EXE_VAddr_i;
                pass_d      = bus.EXE_regData_i;
                if (a_stale_nxt || b_stale_nxt) begin
                    state_d = ST_WAIT;
                end else if (op_e'(bus.EXE_op_i) == OP_MUL) begin
                    state_d = ST_CALC;
                    cnt_d   = MUL_INIT;
                end else begin
                    state_d  = ST_DONE;
                    result_d = alu(op_e'(bus.EXE_op_i), a_nxt, b_nxt, bus.EXE_regData_i);
                end
            end
        end

        valid_d     = (state_d == ST_DONE);
        fwd_valid_d = (state_d == ST_DONE) && (write_num_d != '0);
        fwd_num_d   = (state_d != ST_IDLE) ? write_num_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_PASS;
            write_num_q <= '0;
            vaddr_q     <= '0;
            pass_q      <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_num_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            write_num_q <= write_num_d;
            vaddr_q     <= vaddr_d;
            pass_q      <= pass_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_num_q   <= fwd_num_d;
        end
    end

    assign bus.REEXE_allowin_w_o  = allowin;
    assign bus.REEXE_valid_w_o    = valid_q;
    assign bus.REEXE_writeNum_o   = write_num_q;
    assign bus.REEXE_VAddr_o      = vaddr_q;
    assign bus.REEXE_regData_o    = result_q;
    assign bus.REEXE_fwdValid_w_o = fwd_valid_q;
    assign bus.REEXE_fwdNum_w_o   = fwd_num_q;

endmodule

// File: tb/tb_primary_reexe_stage.sv
// Self-checking bench for primary_reexe_stage: a transaction-level expectation
// queue checked every valid cycle, plus directed literal checks.
module tb_primary_reexe_stage;
    import primary_reexe_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    primary_reexe_stage_if #(.DATA_W(32)) bus();

    primary_reexe_stage #(.MUL_CYCLES(2), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_w_i (flush),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  wnum;
        logic [31:0] vaddr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          hs_cyc_q[$];
    logic [31:0] hs_data_q[$];
    int          asserts  = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] pass);
        case (op)
            2'b01:   return a + b;
            2'b10:   return a - b;
            2'b11:   return a * b;
            default: return pass;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every cycle the stage presents a result, it must be the oldest outstanding one.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.REEXE_valid_w_o) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_valid", {31'b0, bus.REEXE_valid_w_o}, 32'h0);
                end else begin
                    check_output("model_regData", bus.REEXE_regData_o, exp_q[0].data);
                    check_output("model_writeNum", {27'b0, bus.REEXE_writeNum_o}, {27'b0, exp_q[0].wnum});
                    check_output("model_VAddr", bus.REEXE_VAddr_o, exp_q[0].vaddr);
                    check_output("model_fwdValid", {31'b0, bus.REEXE_fwdValid_w_o},
                                 {31'b0, exp_q[0].wnum != 5'd0});
                    check_output("model_fwdNum", {27'b0, bus.REEXE_fwdNum_w_o}, {27'b0, exp_q[0].wnum});
                    if (bus.PBA_okToChange_w_i && !flush) begin
                        hs_cyc_q.push_back(cyc);
                        hs_data_q.push_back(bus.REEXE_regData_o);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check_output("model_fwdValid_idle", {31'b0, bus.REEXE_fwdValid_w_o}, 32'h0);
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] op, input logic [4:0] wnum,
                                  input logic [31:0] vaddr, input logic [31:0] rdata,
                                  input logic [31:0] a, input logic [4:0] anum,
                                  input logic astale, input logic [31:0] a_fwd,
                                  input logic [31:0] b, input logic [4:0] bnum,
                                  input logic bstale, input logic [31:0] b_fwd,
                                  input bit expect_it, output int waited);
        exp_t        e;
        logic [31:0] ea;
        logic [31:0] eb;
        bit          taken;
        ea = !astale ? a : ((anum == 5'd0) ? 32'h0 : a_fwd);
        eb = !bstale ? b : ((bnum == 5'd0) ? 32'h0 : b_fwd);
        if (expect_it) begin
            e.wnum  = wnum;
            e.vaddr = vaddr;
            e.data  = model_result(op, ea, eb, rdata);
            exp_q.push_back(e);
        end
        bus.EXE_op_i        = op;
        bus.EXE_writeNum_i  = wnum;
        bus.EXE_VAddr_i     = vaddr;
        bus.EXE_regData_i   = rdata;
        bus.EXE_srcA_i      = a;
        bus.EXE_srcANum_i   = anum;
        bus.EXE_srcAStale_i = astale;
        bus.EXE_srcB_i      = b;
        bus.EXE_srcBNum_i   = bnum;
        bus.EXE_srcBStale_i = bstale;
        bus.EXE_valid_w_i   = 1'b1;
        waited = 0;
        taken  = 1'b0;
        while (!taken && waited < 50) begin
            @(negedge clk);
            taken = bus.REEXE_allowin_w_o;
            @(posedge clk);
            #1;
            if (!taken) waited++;
        end
        bus.EXE_valid_w_i = 1'b0;
        acc_cyc = cyc;
        if (!taken) check_output("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic expect_hs(input int idx, input int acc, input int lat,
                             input logic [31:0] data, input string name);
        int n = 0;
        while (hs_cyc_q.size() <= idx && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (hs_cyc_q.size() <= idx) begin
            check_output({name, "_timeout"}, hs_cyc_q.size(), idx + 1);
        end else begin
            check_output({name, "_latency"}, hs_cyc_q[idx] - acc + 1, lat);
            check_output({name, "_data"}, hs_data_q[idx], data);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w, w2, acc1, acc2;
        rst   = 1'b1;
        flush = 1'b0;
        bus.EXE_valid_w_i       = 1'b0;
        bus.EXE_op_i            = 2'b00;
        bus.EXE_writeNum_i      = '0;
        bus.EXE_VAddr_i         = '0;
        bus.EXE_regData_i       = '0;
        bus.EXE_srcA_i          = '0;
        bus.EXE_srcB_i          = '0;
        bus.EXE_srcANum_i       = '0;
        bus.EXE_srcBNum_i       = '0;
        bus.EXE_srcAStale_i     = 1'b0;
        bus.EXE_srcBStale_i     = 1'b0;
        bus.PBA_okToChange_w_i  = 1'b1;
        bus.PBA_writeEnable_w_i = 1'b0;
        bus.PBA_writeNum_w_i    = '0;
        bus.PBA_forwardData_w_i = '0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", {31'b0, bus.REEXE_valid_w_o}, 32'h0);
        check_output("rst_writeNum", {27'b0, bus.REEXE_writeNum_o}, 32'h0);
        check_output("rst_VAddr", bus.REEXE_VAddr_o, 32'h0);
        check_output("rst_regData", bus.REEXE_regData_o, 32'h0);
        check_output("rst_fwdValid", {31'b0, bus.REEXE_fwdValid_w_o}, 32'h0);
        check_output("rst_fwdNum", {27'b0, bus.REEXE_fwdNum_w_o}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("idle_allowin", {31'b0, bus.REEXE_allowin_w_o}, 32'h1);

        $display("[TB] PASS op");
        apply_stimulus(2'b00, 5'd3, 32'h100, 32'h1234_5678, 32'h1, 5'd1, 1'b0, 32'h0,
                       32'h2, 5'd2, 1'b0, 32'h0, 1'b1, w);
        acc1 = acc_cyc;
        @(negedge clk);
        check_output("pass_valid", {31'b0, bus.REEXE_valid_w_o}, 32'h1);
        check_output("pass_regData", bus.REEXE_regData_o, 32'h1234_5678);
        check_output("pass_fwdValid", {31'b0, bus.REEXE_fwdValid_w_o}, 32'h1);
        check_output("pass_fwdNum", {27'b0, bus.REEXE_fwdNum_w_o}, 32'd3);
        expect_hs(0, acc1, 1, 32'h1234_5678, "pass");

        $display("[TB] back-to-back ADD/SUB");
        apply_stimulus(2'b01, 5'd4, 32'h104, 32'h0, 32'hFFFF_FFFF, 5'd1, 1'b0, 32'h0,
                       32'h2, 5'd2, 1'b0, 32'h0, 1'b1, w);
        acc1 = acc_cyc;
        apply_stimulus(2'b10, 5'd5, 32'h108, 32'h0, 32'h5, 5'd1, 1'b0, 32'h0,
                       32'h7, 5'd2, 1'b0, 32'h0, 1'b1, w2);
        acc2 = acc_cyc;
        check_output("b2b_allowin_wait", w2, 32'h0);
        check_output("b2b_accept_gap", acc2 - acc1, 32'h1);
        expect_hs(1, acc1, 1, 32'h0000_0001, "add");
        expect_hs(2, acc2, 1, 32'hFFFF_FFFE, "sub");

        $display("[TB] MUL");
        apply_stimulus(2'b11, 5'd6, 32'h10C, 32'h0, 32'h0001_0000, 5'd1, 1'b0, 32'h0,
                       32'h0001_0003, 5'd2, 1'b0, 32'h0, 1'b1, w);
        acc1 = acc_cyc;
        @(negedge clk);
        check_output("mul_allowin_calc0", {31'b0, bus.REEXE_allowin_w_o}, 32'h0);
        @(negedge clk);
        check_output("mul_allowin_calc1", {31'b0, bus.REEXE_allowin_w_o}, 32'h0);
        expect_hs(3, acc1, 3, 32'h0003_0000, "mul");

        $display("[TB] stale srcA");
        apply_stimulus(2'b01, 5'd7, 32'h110, 32'h0, 32'h0, 5'd5, 1'b1, 32'h9,
                       32'h1, 5'd2, 1'b0, 32'h0, 1'b1, w);
        acc1 = acc_cyc;
        bus.PBA_writeEnable_w_i = 1'b1;
        bus.PBA_writeNum_w_i    = 5'd4;
        bus.PBA_forwardData_w_i = 32'hDEAD;
        @(negedge clk);
        check_output("stale_wait0_valid", {31'b0, bus.REEXE_valid_w_o}, 32'h0);
        check_output("stale_wait0_fwdNum", {27'b0, bus.REEXE_fwdNum_w_o}, 32'd7);
        @(posedge clk);
        #1;
        bus.PBA_writeEnable_w_i = 1'b0;
        @(negedge clk);
        check_output("stale_wait1_valid", {31'b0, bus.REEXE_valid_w_o}, 32'h0);
        @(posedge clk);
        #1;
        bus.PBA_writeEnable_w_i = 1'b1;
        bus.PBA_writeNum_w_i    = 5'd5;
        bus.PBA_forwardData_w_i = 32'h9;
        @(posedge clk);
        #1;
        bus.PBA_writeEnable_w_i = 1'b0;
        expect_hs(4, acc1, 4, 32'h0000_000A, "stale_a");

        apply_stimulus(2'b01, 5'd8, 32'h114, 32'h0, 32'h55, 5'd0, 1'b1, 32'h0,
                       32'h3, 5'd2, 1'b0, 32'h0, 1'b1, w);
        expect_hs(5, acc_cyc, 1, 32'h0000_0003, "stale_r0");

        apply_stimulus(2'b10, 5'd9, 32'h118, 32'h0, 32'd50, 5'd1, 1'b0, 32'h0,
                       32'h0, 5'd10, 1'b1, 32'd30, 1'b1, w);
        acc1 = acc_cyc;
        bus.PBA_writeEnable_w_i = 1'b1;
        bus.PBA_writeNum_w_i    = 5'd10;
        bus.PBA_forwardData_w_i = 32'd30;
        @(posedge clk);
        #1;
        bus.PBA_writeEnable_w_i = 1'b0;
        expect_hs(6, acc1, 2, 32'd20, "stale_b");

        $display("[TB] downstream stall");
        bus.PBA_okToChange_w_i = 1'b0;
        apply_stimulus(2'b00, 5'd11, 32'h11C, 32'hCAFE_F00D, 32'h0, 5'd1, 1'b0, 32'h0,
                       32'h0, 5'd2, 1'b0, 32'h0, 1'b1, w);
        acc1 = acc_cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("stall_valid", {31'b0, bus.REEXE_valid_w_o}, 32'h1);
            check_output("stall_regData", bus.REEXE_regData_o, 32'hCAFE_F00D);
        end
        @(posedge clk);
        #1;
        bus.PBA_okToChange_w_i = 1'b1;
        expect_hs(7, acc1, 5, 32'hCAFE_F00D, "stall");

        $display("[TB] flush during CALC");
        apply_stimulus(2'b11, 5'd12, 32'h120, 32'h0, 32'h3, 5'd1, 1'b0, 32'h0,
                       32'h4, 5'd2, 1'b0, 32'h0, 1'b0, w);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_output("flush_allowin", {31'b0, bus.REEXE_allowin_w_o}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check_output("flush_valid", {31'b0, bus.REEXE_valid_w_o}, 32'h0);
            check_output("flush_fwdNum", {27'b0, bus.REEXE_fwdNum_w_o}, 32'h0);
        end
        @(posedge clk);
        #1;
        apply_stimulus(2'b00, 5'd13, 32'h124, 32'h77, 32'h0, 5'd1, 1'b0, 32'h0,
                       32'h0, 5'd2, 1'b0, 32'h0, 1'b1, w);
        expect_hs(8, acc_cyc, 1, 32'h77, "post_flush");

        $display("[TB] async reset in WAIT");
        apply_stimulus(2'b01, 5'd14, 32'h128, 32'h0, 32'h0, 5'd20, 1'b1, 32'h0,
                       32'h1, 5'd2, 1'b0, 32'h0, 1'b0, w);
        @(negedge clk);
        check_output("arst_pre_fwdNum", {27'b0, bus.REEXE_fwdNum_w_o}, 32'd14);
        #2;
        rst = 1'b1;
        #1;
        check_output("arst_valid", {31'b0, bus.REEXE_valid_w_o}, 32'h0);
        check_output("arst_writeNum", {27'b0, bus.REEXE_writeNum_o}, 32'h0);
        check_output("arst_VAddr", bus.REEXE_VAddr_o, 32'h0);
        check_output("arst_regData", bus.REEXE_regData_o, 32'h0);
        check_output("arst_fwdNum", {27'b0, bus.REEXE_fwdNum_w_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("arst_allowin", {31'b0, bus.REEXE_allowin_w_o}, 32'h1);
        @(posedge clk);
        #1;
        apply_stimulus(2'b00, 5'd15, 32'h12C, 32'h5A5A_5A5A, 32'h0, 5'd1, 1'b0, 32'h0,
                       32'h0, 5'd2, 1'b0, 32'h0, 1'b1, w);
        expect_hs(9, acc_cyc, 1, 32'h5A5A_5A5A, "post_reset");

        repeat (3) @(posedge clk);
        #1;
        check_output("queue_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
